// File: rtl/mlp_neuron_acc.sv
// Neuron accumulator: sums N_INPUTS signed products plus a bias, then rounds,
// rescales, applies optional ReLU and saturates to the activation format.
module mlp_neuron_acc #(
    parameter int PROD_WIDTH = 36,
    parameter int ACC_WIDTH  = 48,
    parameter int OUT_WIDTH  = 18,
    parameter int FRAC_BITS  = 10,
    parameter int N_INPUTS   = 16,
    parameter int RELU_EN    = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic [OUT_WIDTH-1:0]  bias,
    input  logic                  abort,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_sat
);

    localparam int CNT_W = (N_INPUTS > 1) ? $clog2(N_INPUTS + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_INPUTS - 1);

    localparam logic signed [ACC_WIDTH:0] ROUND_HALF =
        {{ACC_WIDTH{1'b0}}, 1'b1} << (FRAC_BITS - 1);
    localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MAX_WIDE =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b0}}, OUT_MAX};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN_WIDE =
        {{(ACC_WIDTH-OUT_WIDTH+1){1'b1}}, OUT_MIN};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_FINISH,
        ST_OUTPUT
    } state_t;

    state_t                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]              count_q, count_d;
    logic                          out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]          out_data_q, out_data_d;
    logic                          out_sat_q, out_sat_d;

    logic                          beat_accept;
    logic signed [ACC_WIDTH-1:0]   prod_ext;
    logic signed [ACC_WIDTH-1:0]   bias_ext;
    logic signed [ACC_WIDTH:0]     acc_wide;
    logic signed [ACC_WIDTH:0]     rnd_sum;
    logic signed [ACC_WIDTH:0]     rnd_shift;
    logic signed [ACC_WIDTH:0]     act_val;
    logic [OUT_WIDTH-1:0]          res_data;
    logic                          res_sat;

    assign prod_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign beat_accept = prod_valid && prod_ready;

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    assign bias_ext = {{(ACC_WIDTH-OUT_WIDTH){bias[OUT_WIDTH-1]}}, bias} << FRAC_BITS;

    // One extra bit of headroom so the rounding offset cannot wrap the sum.
    always_comb begin
        acc_wide  = {acc_q[ACC_WIDTH-1], acc_q};
        rnd_sum   = acc_wide + ROUND_HALF;
        rnd_shift = rnd_sum >>> FRAC_BITS;
        act_val   = rnd_shift;
        if ((RELU_EN != 0) && rnd_shift[ACC_WIDTH]) begin
            act_val = '0;
        end
        res_data = act_val[OUT_WIDTH-1:0];
        res_sat  = 1'b0;
        if (act_val > OUT_MAX_WIDE) begin
            res_data = OUT_MAX;
            res_sat  = 1'b1;
        end else if (act_val < OUT_MIN_WIDE) begin
            res_data = OUT_MIN;
            res_sat  = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        count_d     = count_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (abort) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (beat_accept) begin
                        acc_d   = bias_ext + prod_ext;
                        count_d = CNT_W'(1);
                        state_d = (N_INPUTS == 1) ? ST_FINISH : ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (beat_accept) begin
                        acc_d   = acc_q + prod_ext;
                        count_d = count_q + CNT_W'(1);
                        if (count_q == LAST_CNT) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    out_valid_d = 1'b1;
                    out_data_d  = res_data;
                    out_sat_d   = res_sat;
                    state_d     = ST_OUTPUT;
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        out_valid_d = 1'b0;
                        acc_d       = '0;
                        count_d     = '0;
                        state_d     = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_mlp_neuron_acc.sv
// Bench for mlp_neuron_acc: three instances (N=4 ReLU, N=4 linear, N=1 linear)
// driven with directed and random neurons, checked against an arithmetic model.
module tb_mlp_neuron_acc;

    localparam int PW = 36;
    localparam int AW = 48;
    localparam int OW = 18;
    localparam int FB = 10;
    localparam int N_OF[3]    = '{4, 4, 1};
    localparam bit RELU_OF[3] = '{1'b1, 1'b0, 1'b0};

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic                 pv[3];
    logic                 pr[3];
    logic [PW-1:0]        pd[3];
    logic [OW-1:0]        bs[3];
    logic                 ab[3];
    logic                 ov[3];
    logic                 ordy[3];
    logic signed [OW-1:0] od[3];
    logic                 os[3];

    int checks = 0;
    int errors = 0;

    mlp_neuron_acc #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .FRAC_BITS(FB),
                     .N_INPUTS(4), .RELU_EN(1)) u_relu4 (
        .clk(clk), .reset(reset), .prod_valid(pv[0]), .prod_ready(pr[0]),
        .prod_data(pd[0]), .bias(bs[0]), .abort(ab[0]), .out_valid(ov[0]),
        .out_ready(ordy[0]), .out_data(od[0]), .out_sat(os[0]));

    mlp_neuron_acc #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .FRAC_BITS(FB),
                     .N_INPUTS(4), .RELU_EN(0)) u_lin4 (
        .clk(clk), .reset(reset), .prod_valid(pv[1]), .prod_ready(pr[1]),
        .prod_data(pd[1]), .bias(bs[1]), .abort(ab[1]), .out_valid(ov[1]),
        .out_ready(ordy[1]), .out_data(od[1]), .out_sat(os[1]));

    mlp_neuron_acc #(.PROD_WIDTH(PW), .ACC_WIDTH(AW), .OUT_WIDTH(OW), .FRAC_BITS(FB),
                     .N_INPUTS(1), .RELU_EN(0)) u_lin1 (
        .clk(clk), .reset(reset), .prod_valid(pv[2]), .prod_ready(pr[2]),
        .prod_data(pd[2]), .bias(bs[2]), .abort(ab[2]), .out_valid(ov[2]),
        .out_ready(ordy[2]), .out_data(od[2]), .out_sat(os[2]));

    task automatic checkOutput(input string tag, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
        end
    endtask

    // Real-valued view: bias scaled to product precision, exact sum, floor of (sum+half)/scale.
    function automatic void ref_model(input int idx, input longint b, input longint prods[$],
                                      output longint data, output longint sat);
        longint sum;
        longint t;
        longint r;
        longint scale;
        longint vmax;
        longint vmin;
        scale = 64'sd1 << FB;
        vmax  = (64'sd1 << (OW - 1)) - 1;
        vmin  = -(64'sd1 << (OW - 1));
        sum   = b * scale;
        foreach (prods[k]) sum += prods[k];
        t = sum + scale / 2;
        if (t >= 0) r = t / scale;
        else        r = -((-t + scale - 1) / scale);
        if (RELU_OF[idx] && r < 0) r = 0;
        sat  = 0;
        data = r;
        if (r > vmax) begin
            data = vmax;
            sat  = 1;
        end else if (r < vmin) begin
            data = vmin;
            sat  = 1;
        end
    endfunction

    task automatic applyStimulus(input int idx, input logic signed [OW-1:0] b,
                                 input longint prods[$], input int max_gap, input int hold);
        longint exp_d;
        longint exp_s;
        ref_model(idx, longint'(b), prods, exp_d, exp_s);
        @(negedge clk);
        bs[idx]   = b;
        ordy[idx] = 1'b0;
        foreach (prods[k]) begin
            repeat ($urandom_range(0, max_gap)) begin
                pv[idx] = 1'b0;
                pd[idx] = {$urandom, $urandom};
                @(negedge clk);
            end
            pv[idx] = 1'b1;
            pd[idx] = prods[k][PW-1:0];
            checkOutput("ready_while_accum", longint'(pr[idx]), 1);
            @(negedge clk);
            bs[idx] = OW'($urandom);
        end
        pv[idx]   = 1'b1;
        pd[idx]   = {$urandom, $urandom};
        ordy[idx] = (hold == 0);
        checkOutput("finish_ready_low", longint'(pr[idx]), 0);
        checkOutput("finish_valid_low", longint'(ov[idx]), 0);
        @(negedge clk);
        checkOutput("latency_valid", longint'(ov[idx]), 1);
        checkOutput("out_data", longint'(od[idx]), exp_d);
        checkOutput("out_sat", longint'(os[idx]), exp_s);
        checkOutput("output_ready_low", longint'(pr[idx]), 0);
        for (int h = 0; h < hold; h++) begin
            pd[idx] = {$urandom, $urandom};
            @(negedge clk);
            checkOutput("hold_valid", longint'(ov[idx]), 1);
            checkOutput("hold_data", longint'(od[idx]), exp_d);
            checkOutput("hold_sat", longint'(os[idx]), exp_s);
            checkOutput("hold_ready_low", longint'(pr[idx]), 0);
        end
        ordy[idx] = 1'b1;
        @(negedge clk);
        pv[idx]   = 1'b0;
        ordy[idx] = 1'b0;
        checkOutput("post_handshake_valid", longint'(ov[idx]), 0);
        checkOutput("post_handshake_ready", longint'(pr[idx]), 1);
    endtask

    task automatic abort_test(input int idx, input int nbeats, input bit wait_output);
        @(negedge clk);
        bs[idx] = OW'($urandom);
        for (int k = 0; k < nbeats; k++) begin
            pv[idx] = 1'b1;
            pd[idx] = {$urandom, $urandom};
            @(negedge clk);
        end
        pv[idx] = 1'b0;
        if (wait_output) begin
            @(negedge clk);
            checkOutput("abort_pre_valid", longint'(ov[idx]), 1);
        end
        ab[idx] = 1'b1;
        pv[idx] = 1'b1;
        pd[idx] = {$urandom, $urandom};
        @(negedge clk);
        ab[idx] = 1'b0;
        pv[idx] = 1'b0;
        checkOutput("abort_valid", longint'(ov[idx]), 0);
        checkOutput("abort_ready", longint'(pr[idx]), 1);
    endtask

    task automatic reset_test(input int idx);
        @(negedge clk);
        bs[idx] = OW'($urandom);
        for (int k = 0; k < 2; k++) begin
            pv[idx] = 1'b1;
            pd[idx] = {$urandom, $urandom};
            @(negedge clk);
        end
        pv[idx] = 1'b0;
        reset = 1'b1;
        #1;
        checkOutput("async_reset_valid", longint'(ov[idx]), 0);
        checkOutput("async_reset_data", longint'(od[idx]), 0);
        checkOutput("async_reset_sat", longint'(os[idx]), 0);
        checkOutput("async_reset_ready", longint'(pr[idx]), 1);
        #2;
        reset = 1'b0;
    endtask

    longint q[$];
    longint one_one;
    longint big;

    initial begin
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; pd[i] = '0; bs[i] = '0; ab[i] = 1'b0; ordy[i] = 1'b0;
        end
        one_one = 64'sd1 << (2 * FB);
        big     = 64'sd1 << 34;
        reset   = 1'b1;
        #12;
        for (int i = 0; i < 3; i++) begin
            checkOutput("reset_valid", longint'(ov[i]), 0);
            checkOutput("reset_data", longint'(od[i]), 0);
            checkOutput("reset_sat", longint'(os[i]), 0);
            checkOutput("reset_ready", longint'(pr[i]), 1);
        end
        reset = 1'b0;

        q = '{one_one, one_one, one_one, one_one};
        applyStimulus(0, 18'sd512, q, 0, 0);
        q = '{big, big, big, big};
        applyStimulus(0, 18'sd0, q, 0, 0);
        q = '{-big, -big, -big, -big};
        applyStimulus(0, 18'sd0, q, 0, 0);
        applyStimulus(1, 18'sd0, q, 0, 0);

        q = '{64'sd1536};  applyStimulus(2, 18'sd0, q, 0, 0);
        q = '{-64'sd1536}; applyStimulus(2, 18'sd0, q, 0, 0);
        q = '{64'sd511};   applyStimulus(2, 18'sd0, q, 0, 0);
        q = '{64'sd512};   applyStimulus(2, 18'sd0, q, 0, 0);
        q = '{-64'sd512};  applyStimulus(2, 18'sd0, q, 0, 0);

        q = '{one_one, -one_one, one_one, 64'sd7};
        applyStimulus(0, 18'sd300, q, 0, 5);
        q = '{one_one, one_one, one_one, one_one};
        applyStimulus(0, -18'sd2048, q, 0, 0);
        applyStimulus(1, 18'sd0, q, 2, 0);

        abort_test(0, 2, 1'b0);
        q = '{one_one, one_one, 64'sd3 << 19, -one_one};
        applyStimulus(0, 18'sd100, q, 1, 0);
        abort_test(1, 4, 1'b1);
        q = '{-one_one, 64'sd12345, one_one, one_one};
        applyStimulus(1, -18'sd77, q, 0, 1);
        reset_test(0);
        q = '{one_one, one_one, one_one, one_one};
        applyStimulus(0, 18'sd0, q, 0, 0);

        for (int t = 0; t < 30; t++) begin
            int idx;
            logic signed [OW-1:0] b;
            longint raw;
            idx = $urandom_range(0, 2);
            b   = OW'($urandom);
            q.delete();
            for (int k = 0; k < N_OF[idx]; k++) begin
                raw = {$urandom, $urandom};
                q.push_back(raw >>> (28 + $urandom_range(0, 27)));
            end
            applyStimulus(idx, b, q, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
